// File: rtl/decode_regfile_pkg.sv
// Shared types and constants for the decode-side register file and D/E register.
// Optional REGFILE_BYPASS_EN enables same-cycle write-through on the read ports.
package decode_regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_A0   = 5'd10;

   typedef struct packed {
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [ADDR_W-1:0] rs1;
      logic [ADDR_W-1:0] rs2;
      logic [ADDR_W-1:0] rd;
   } de_payload_t;

endpackage

// File: rtl/decode_regfile_regfile.sv
// Integer register file: one write port, two combinational read ports, a0 tap.
// With REGFILE_BYPASS_EN defined, a same-cycle write to a read index is forwarded.
module decode_regfile_regfile
   import decode_regfile_pkg::*;
#(
   parameter int WIDTH      = DATA_W,
   parameter int ADDR_WIDTH = ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [WIDTH-1:0]      rdata1,
   output logic [WIDTH-1:0]      rdata2,
   output logic [WIDTH-1:0]      a0
);

   localparam int NREG = 2 ** ADDR_WIDTH;

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
   logic             wr_en;

   assign wr_en = we && (waddr != REG_ZERO);

   always_comb begin
      // NOTE: start from the current value so every path assigns regs_d; otherwise a latch is inferred.
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[waddr] = wdata;
      end
   end

   // NOTE: the array is reset because the architectural reset state is all-zero registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rdata1 = (raddr1 == REG_ZERO) ? '0 : regs_q[raddr1];
      rdata2 = (raddr2 == REG_ZERO) ? '0 : regs_q[raddr2];
`ifdef REGFILE_BYPASS_EN
      // wr_en already excludes x0, so the zero register is never forwarded.
      if (wr_en && (waddr == raddr1)) rdata1 = wdata;
      if (wr_en && (waddr == raddr2)) rdata2 = wdata;
`endif
   end

   assign a0 = regs_q[REG_A0];

endmodule

// File: rtl/decode_regfile.sv
// Decode stage register file plus the Decode-to-Execute pipeline register.
// Define REGFILE_BYPASS_EN for write-through of the writeback result into D/E.
module decode_regfile
   import decode_regfile_pkg::*;
#(
   parameter int WIDTH      = DATA_W,
   parameter int ADDR_WIDTH = ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RegWriteW,
   input  logic [ADDR_WIDTH-1:0] RdW,
   input  logic [WIDTH-1:0]      ResultW,
   input  logic [ADDR_WIDTH-1:0] Rs1D,
   input  logic [ADDR_WIDTH-1:0] Rs2D,
   input  logic [ADDR_WIDTH-1:0] RdD,
   input  logic                  StallE,
   input  logic                  FlushE,
   output logic [WIDTH-1:0]      RD1E,
   output logic [WIDTH-1:0]      RD2E,
   output logic [ADDR_WIDTH-1:0] Rs1E,
   output logic [ADDR_WIDTH-1:0] Rs2E,
   output logic [ADDR_WIDTH-1:0] RdE,
   output logic [WIDTH-1:0]      a0
);

   logic [WIDTH-1:0] rd1_data;
   logic [WIDTH-1:0] rd2_data;
   de_payload_t      de_q;
   de_payload_t      de_d;

   decode_regfile_regfile #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (RegWriteW),
      .waddr  (RdW),
      .wdata  (ResultW),
      .raddr1 (Rs1D),
      .raddr2 (Rs2D),
      .rdata1 (rd1_data),
      .rdata2 (rd2_data),
      .a0     (a0)
   );

   // Flush beats stall: a bubble carries RdE=0 so hazard logic ignores it.
   always_comb begin
      de_d = de_q;
      if (FlushE) begin
         de_d = '0;
      end else if (!StallE) begin
         de_d.rd1 = rd1_data;
         de_d.rd2 = rd2_data;
         de_d.rs1 = Rs1D;
         de_d.rs2 = Rs2D;
         de_d.rd  = RdD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_q <= '0;
      end else begin
         de_q <= de_d;
      end
   end

   assign RD1E = de_q.rd1;
   assign RD2E = de_q.rd2;
   assign Rs1E = de_q.rs1;
   assign Rs2E = de_q.rs2;
   assign RdE  = de_q.rd;

endmodule
